// File: rtl/sram_arbiter.sv
// Shares one single-ported, 1-cycle-latency SRAM between instruction fetch and data access.
// Data has fixed priority; a streak counter forces a fetch through after MAX_D_STREAK data wins.
module sram_arbiter #(
   parameter int MAX_D_STREAK = 4
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        inst_req,
   input  logic [31:0] inst_addr,
   output logic        inst_addr_ok,
   output logic        inst_data_ok,
   output logic [31:0] inst_rdata,
   input  logic        data_req,
   input  logic        data_wr,
   input  logic [3:0]  data_wstrb,
   input  logic [31:0] data_addr,
   input  logic [31:0] data_wdata,
   output logic        data_addr_ok,
   output logic        data_data_ok,
   output logic [31:0] data_rdata,
   output logic        sram_en,
   output logic [3:0]  sram_wen,
   output logic [31:0] sram_addr,
   output logic [31:0] sram_wdata,
   input  logic [31:0] sram_rdata
);

   localparam logic [3:0] MAX_S = 4'(MAX_D_STREAK);

   logic [3:0] streak_q, streak_d;
   logic       resp_valid_q;
   logic       resp_owner_q;
   logic       gnt_d, gnt_i;

   // No grant may leave the block while reset is asserted.
   always_comb begin
      gnt_d = ~reset & data_req & ~(inst_req & (streak_q == MAX_S));
      gnt_i = ~reset & inst_req & ~gnt_d;
   end

   assign inst_addr_ok = gnt_i;
   assign data_addr_ok = gnt_d;

   assign sram_en    = gnt_i | gnt_d;
   assign sram_addr  = gnt_d ? data_addr : (gnt_i ? inst_addr : 32'h0);
   assign sram_wen   = (gnt_d & data_wr) ? data_wstrb : 4'b0;
   assign sram_wdata = gnt_d ? data_wdata : 32'h0;

   always_comb begin
      streak_d = streak_q;
      if (gnt_i || !inst_req)
         streak_d = 4'd0;
      else if (gnt_d && streak_q != MAX_S)
         streak_d = streak_q + 4'd1;
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         streak_q     <= 4'd0;
         resp_valid_q <= 1'b0;
         resp_owner_q <= 1'b0;
      end else begin
         streak_q     <= streak_d;
         resp_valid_q <= sram_en;
         resp_owner_q <= gnt_d;
      end
   end

   // rdata is gated by resp_valid so that both read buses stay 0 when idle and in reset.
   assign inst_data_ok = resp_valid_q & ~resp_owner_q;
   assign data_data_ok = resp_valid_q &  resp_owner_q;
   assign inst_rdata   = inst_data_ok ? sram_rdata : 32'h0;
   assign data_rdata   = data_data_ok ? sram_rdata : 32'h0;

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter: reset, fetch, store, starvation, ordering, mid-access reset.
module tb_sram_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        inst_req;
   logic [31:0] inst_addr;
   logic        inst_addr_ok, inst_data_ok;
   logic [31:0] inst_rdata;
   logic        data_req, data_wr;
   logic [3:0]  data_wstrb;
   logic [31:0] data_addr, data_wdata;
   logic        data_addr_ok, data_data_ok;
   logic [31:0] data_rdata;
   logic        sram_en;
   logic [3:0]  sram_wen;
   logic [31:0] sram_addr, sram_wdata, sram_rdata;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   sram_arbiter #(.MAX_D_STREAK(4)) dut (
      .clk(clk), .reset(reset),
      .inst_req(inst_req), .inst_addr(inst_addr),
      .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
      .data_req(data_req), .data_wr(data_wr), .data_wstrb(data_wstrb),
      .data_addr(data_addr), .data_wdata(data_wdata),
      .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
      .sram_en(sram_en), .sram_wen(sram_wen), .sram_addr(sram_addr),
      .sram_wdata(sram_wdata), .sram_rdata(sram_rdata)
   );

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
      end
   endtask

   // Advance to the falling edge; inputs set after this take effect before the next rising edge.
   task automatic step();
      @(negedge clk);
   endtask

   logic [11:0] starve_pat;
   int          inst_ok_cnt;

   initial begin
      reset = 1'b1; inst_req = 1'b1; data_req = 1'b1;
      inst_addr = 32'h20; data_addr = 32'h40; data_wr = 1'b0;
      data_wstrb = 4'hF; data_wdata = 32'h11223344; sram_rdata = 32'h55;

      // Reset held with both requests high
      repeat (3) step();
      #1;
      check("rst_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      check("rst_data_addr_ok", 32'(data_addr_ok), 32'd0);
      check("rst_inst_data_ok", 32'(inst_data_ok), 32'd0);
      check("rst_data_data_ok", 32'(data_data_ok), 32'd0);
      check("rst_inst_rdata",   inst_rdata, 32'd0);
      check("rst_data_rdata",   data_rdata, 32'd0);
      check("rst_sram_en",      32'(sram_en), 32'd0);
      check("rst_sram_wen",     32'(sram_wen), 32'd0);
      check("rst_sram_addr",    sram_addr, 32'd0);
      check("rst_sram_wdata",   sram_wdata, 32'd0);
      $display("txn reset_hold done");

      // Release: data wins the first cycle
      step(); reset = 1'b0; #1;
      check("rel_data_addr_ok", 32'(data_addr_ok), 32'd1);
      check("rel_inst_addr_ok", 32'(inst_addr_ok), 32'd0);
      check("rel_sram_addr",    sram_addr, 32'h40);
      check("rel_sram_wen",     32'(sram_wen), 32'd0);
      step(); inst_req = 1'b0; data_req = 1'b0; sram_rdata = 32'h12345678; #1;
      check("rel_data_data_ok", 32'(data_data_ok), 32'd1);
      check("rel_data_rdata",   data_rdata, 32'h12345678);
      check("rel_inst_data_ok", 32'(inst_data_ok), 32'd0);
      check("rel_inst_rdata",   inst_rdata, 32'd0);
      $display("txn reset_release load addr=0x40 rdata=0x%08h", data_rdata);

      // Fetch alone for 3 cycles, plus one trailing cycle for the last response
      inst_addr = 32'h1C;
      for (int i = 0; i < 4; i++) begin
         step(); inst_req = (i < 3); sram_rdata = 32'h100 + 32'(i); #1;
         if (i < 3) begin
            check("fetch_addr_ok", 32'(inst_addr_ok), 32'd1);
            check("fetch_sram_addr", sram_addr, 32'h1C);
            check("fetch_sram_wen", 32'(sram_wen), 32'd0);
         end
         check("fetch_inst_data_ok", 32'(inst_data_ok), (i > 0) ? 32'd1 : 32'd0);
         if (i > 0) check("fetch_inst_rdata", inst_rdata, 32'h100 + 32'(i));
         check("fetch_data_data_ok", 32'(data_data_ok), 32'd0);
         $display("txn fetch cycle=%0d addr_ok=%0b data_ok=%0b", i, inst_addr_ok, inst_data_ok);
      end

      // Store with partial strobe
      step(); data_req = 1'b1; data_wr = 1'b1; data_wstrb = 4'b0011;
      data_addr = 32'h100; data_wdata = 32'hDEADBEEF; #1;
      check("st_addr_ok",   32'(data_addr_ok), 32'd1);
      check("st_sram_en",   32'(sram_en), 32'd1);
      check("st_sram_wen",  32'(sram_wen), 32'b0011);
      check("st_sram_addr", sram_addr, 32'h100);
      check("st_sram_wdata", sram_wdata, 32'hDEADBEEF);
      step(); data_wstrb = 4'b0000; data_addr = 32'h104; #1;
      check("st_data_ok",      32'(data_data_ok), 32'd1);
      check("st_inst_data_ok", 32'(inst_data_ok), 32'd0);
      // Zero-strobe store is still granted as a no-write access
      check("st0_sram_en",  32'(sram_en), 32'd1);
      check("st0_sram_wen", 32'(sram_wen), 32'd0);
      step(); data_req = 1'b0; data_wr = 1'b0; #1;
      check("st0_data_ok", 32'(data_data_ok), 32'd1);
      $display("txn store addr=0x100 wstrb=0011 and store addr=0x104 wstrb=0000");

      // Starvation: pattern bit c = 1 means data granted in cycle c
      starve_pat  = 12'b1101111_01111;   // cycles 11..0: D,D,I,D,D,D,D,I,D,D,D,D read right-to-left
      starve_pat  = {1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1,1'b0,1'b1,1'b1,1'b1,1'b1};
      inst_ok_cnt = 0;
      data_addr = 32'h300; inst_addr = 32'h24;
      for (int c = 0; c < 13; c++) begin
         step(); inst_req = (c < 12); data_req = (c < 12); #1;
         if (inst_data_ok) inst_ok_cnt++;
         if (c < 12) begin
            check("starve_gnt_d", 32'(data_addr_ok), 32'(starve_pat[c]));
            check("starve_gnt_i", 32'(inst_addr_ok), 32'(!starve_pat[c]));
            $display("txn starve cycle=%0d grant=%s", c, data_addr_ok ? "D" : (inst_addr_ok ? "I" : "-"));
         end
      end
      check("starve_inst_ok_count", 32'(inst_ok_cnt), 32'd2);

      // Alternating owners return in order
      step(); inst_req = 1'b1; inst_addr = 32'h8; #1;
      check("alt_inst_addr_ok", 32'(inst_addr_ok), 32'd1);
      step(); inst_req = 1'b0; data_req = 1'b1; data_addr = 32'h200; sram_rdata = 32'hA; #1;
      check("alt_data_addr_ok",  32'(data_addr_ok), 32'd1);
      check("alt_inst_data_ok",  32'(inst_data_ok), 32'd1);
      check("alt_inst_rdata",    inst_rdata, 32'hA);
      check("alt_data_data_ok0", 32'(data_data_ok), 32'd0);
      check("alt_data_rdata0",   data_rdata, 32'd0);
      step(); data_req = 1'b0; sram_rdata = 32'hB; #1;
      check("alt_data_data_ok",  32'(data_data_ok), 32'd1);
      check("alt_data_rdata",    data_rdata, 32'hB);
      check("alt_inst_data_ok1", 32'(inst_data_ok), 32'd0);
      check("alt_inst_rdata1",   inst_rdata, 32'd0);
      $display("txn alternate inst=0xA data=0xB");

      // Mid-access reset: streak is pushed to 1, then reset drops the pending load
      step(); data_req = 1'b1; inst_req = 1'b1; #1;
      check("mid_data_addr_ok", 32'(data_addr_ok), 32'd1);
      step(); data_req = 1'b0; inst_req = 1'b0; reset = 1'b1; #1;
      check("mid_data_ok_in_reset", 32'(data_data_ok), 32'd0);
      check("mid_rdata_in_reset",   data_rdata, 32'd0);
      step(); reset = 1'b0; #1;
      check("mid_data_ok_after", 32'(data_data_ok), 32'd0);
      // A cleared streak gives four data grants before the fetch wins
      for (int c = 0; c < 5; c++) begin
         step(); data_req = 1'b1; inst_req = 1'b1; #1;
         check("mid_streak_gnt_d", 32'(data_addr_ok), (c < 4) ? 32'd1 : 32'd0);
      end
      step(); data_req = 1'b0; inst_req = 1'b1; inst_addr = 32'h30; #1;
      check("mid_lone_inst_ok", 32'(inst_addr_ok), 32'd1);
      check("mid_lone_sram_addr", sram_addr, 32'h30);
      $display("txn mid_reset recovery inst_addr_ok=%0b", inst_addr_ok);

      step(); inst_req = 1'b0;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "timeout");
   end

endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Shares one single-ported, 1-cycle-read-latency SRAM between the instruction-fetch requester and the data requester. It sits between if_stage/exe_stage/mem_stage and a unified memory, replacing the separate instr/data SRAM interfaces on the cpu boundary. Each port uses a req/addr_ok request phase and a data_ok response phase. The data port has fixed priority, and a starvation counter guarantees fetch progress.

## Interface
- MAX_D_STREAK, default 4: consecutive data grants allowed while inst_req is waiting before fetch is forced through (legal range 1..15).
- clk  in  1  clock; all state updates on rising edge.
- reset  in  1  asynchronous, active-high reset.
- inst_req  in  1  fetch request; inst_addr held stable until inst_addr_ok.
- inst_addr  in  32  fetch byte address (word aligned).
- inst_addr_ok  out  1  fetch request granted this cycle.
- inst_data_ok  out  1  fetch data valid on inst_rdata this cycle.
- inst_rdata  out  32  fetch read data.
- data_req  in  1  data request; data_wr/wstrb/addr/wdata held stable until data_addr_ok.
- data_wr  in  1  1 = store, 0 = load.
- data_wstrb  in  4  byte write enables (store only).
- data_addr  in  32  data byte address.
- data_wdata  in  32  store data.
- data_addr_ok  out  1  data request granted this cycle.
- data_data_ok  out  1  data response this cycle (load data or store completion).
- data_rdata  out  32  load data.
- sram_en  out  1  SRAM access enable.
- sram_wen  out  4  SRAM byte write enables.
- sram_addr  out  32  SRAM address.
- sram_wdata  out  32  SRAM write data.
- sram_rdata  in  32  SRAM read data, valid the cycle after sram_en.

## Operation
- Grant is combinational, at most one per cycle, and no grant is issued while reset is high:
  - gnt_d = data_req & ~(inst_req & streak==MAX_D_STREAK).
  - gnt_i = inst_req & ~gnt_d.
- inst_addr_ok = gnt_i. data_addr_ok = gnt_d.
- SRAM drive:
  - sram_en = gnt_i | gnt_d.
  - sram_addr = gnt_d ? data_addr : gnt_i ? inst_addr : 0.
  - sram_wen = (gnt_d & data_wr) ? data_wstrb : 4'b0.
  - sram_wdata = gnt_d ? data_wdata : 0.
- Streak counter (4 bits):
  - gnt_d & inst_req: increment, saturating at MAX_D_STREAK.
  - gnt_i or ~inst_req: clear to 0.
  - Otherwise: hold.
- Response tracker: registers resp_valid and resp_owner (0 = inst, 1 = data). On every edge, resp_valid <= sram_en and resp_owner <= gnt_d.
- Response outputs:
  - inst_data_ok = resp_valid & ~resp_owner.
  - data_data_ok = resp_valid & resp_owner.
  - The owner's rdata = sram_rdata; the non-owner's rdata = 0.
- Stores also return data_data_ok. data_rdata for a store is don't-care.
- There is no backpressure on data_ok; requesters must accept the response in that cycle.
- A store with data_wstrb = 0 is granted and completes as a no-write access.

## Timing
- Reset (asynchronous assert, synchronous use after release): resp_valid = 0, resp_owner = 0, streak = 0.
- During reset all outputs are 0: addr_ok both 0, data_ok both 0, rdata both 0, sram_en = 0, sram_wen = 0, sram_addr = 0, sram_wdata = 0.
- Request-to-grant latency is 0 cycles when the port wins arbitration.
- Grant-to-data_ok latency is exactly 1 cycle.
- Throughput is one access per cycle. Back-to-back grants to alternating owners each return in order, one cycle apart.
- Simultaneous inst_req & data_req with streak < MAX_D_STREAK: data wins and streak increments.
- When streak == MAX_D_STREAK with both requesting: inst wins, streak clears, data waits 1 cycle.
- Reset asserted mid-access: the pending response is dropped (no data_ok after reset) and the requester reissues.

## Test plan
- Reset: hold reset with both reqs high -> all outputs 0. Release -> first cycle data_addr_ok=1, sram_addr=data_addr; next cycle data_data_ok=1, data_rdata=sram_rdata.
- Fetch alone: inst_req=1, inst_addr=0x1C for 3 cycles -> inst_addr_ok=1 every cycle, sram_wen=0, inst_data_ok=1 each following cycle, data_data_ok=0 throughout.
- Store: data_req=1, data_wr=1, wstrb=4'b0011, addr=0x100, wdata=0xDEADBEEF -> same cycle sram_en=1, sram_wen=4'b0011, sram_wdata=0xDEADBEEF; next cycle data_data_ok=1, inst_data_ok=0.
- Starvation (MAX_D_STREAK=4): both reqs held high for 12 cycles -> grant pattern D,D,D,D,I repeating (D,D,D,D,I,D,D,D,D,I,D,D); inst_data_ok exactly 2 times.
- Alternation ordering: inst grant at cycle n, data load at n+1 with sram_rdata=0xA then 0xB -> inst_rdata=0xA at n+1, data_rdata=0xB at n+2, each data_ok high only for its owner.
- Mid-operation reset: grant a load, assert reset the next cycle -> data_data_ok stays 0; after release streak=0 and a lone inst_req is granted immediately.
